// File: rtl/pipelined_alu.sv
// Handshaked ALU: one op per valid/ready transfer; optional shift-add MUL under PIPELINED_ALU_MUL_EN.
// Single-cycle ops land one cycle after accept, MUL after WIDTH cycles; a pending result stalls in_ready.
module pipelined_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [5:0]       status
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_NEG = 5'd2;
  localparam logic [4:0] OP_INC = 5'd3;
  localparam logic [4:0] OP_DEC = 5'd4;
  localparam logic [4:0] OP_MOV = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_OR  = 5'd7;
  localparam logic [4:0] OP_XOR = 5'd8;
  localparam logic [4:0] OP_NOT = 5'd9;
  localparam logic [4:0] OP_ASR = 5'd10;
  localparam logic [4:0] OP_ASL = 5'd11;
  localparam logic [4:0] OP_LSR = 5'd12;
  localparam logic [4:0] OP_LSL = 5'd13;
  localparam logic [4:0] OP_CSR = 5'd14;
  localparam logic [4:0] OP_CSL = 5'd15;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef PIPELINED_ALU_MUL_EN
  localparam logic [4:0]     OP_MUL = 5'd16;
  localparam logic [SHW-1:0] LAST   = SHW'(WIDTH-1);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [5:0]       status_q, status_d;
  logic             accept;

  function automatic logic [5:0] pack_status(input logic [WIDTH-1:0] v, input logic e,
                                             input logic vf, input logic c);
    return {e, ^v, vf, v[WIDTH-1], (v == '0), c};
  endfunction

  // Datapath for every single-cycle opcode
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] opb, neg_y, shl_y, lsr_y, asr_y, csr_y, csl_y;
  logic [WIDTH:0]   sum, diff, shl_ext;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v, alu_e;

  assign sh      = b[SHW-1:0];
  assign opb     = (opcode == OP_INC || opcode == OP_DEC) ? ONE : b;
  assign sum     = {1'b0, a} + {1'b0, opb};
  assign diff    = {1'b0, a} - {1'b0, opb};
  assign neg_y   = '0 - a;
  assign shl_y   = a << sh;
  assign shl_ext = {1'b0, a} << sh;
  assign lsr_y   = a >> sh;
  assign asr_y   = $unsigned($signed(a) >>> sh);
  assign csr_y   = lsr_y | (a << (WIDTH - int'(sh)));
  assign csl_y   = shl_y | (a >> (WIDTH - int'(sh)));

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (opcode)
      OP_ADD, OP_INC: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_y = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (a[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NEG: begin
        alu_y = neg_y;
        alu_c = (a != '0);
        alu_v = (a == MSB_ONE);
      end
      OP_MOV: alu_y = a;
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_XOR: alu_y = a ^ b;
      OP_NOT: alu_y = ~a;
      OP_ASL, OP_LSL: begin
        alu_y = shl_y;
        alu_c = shl_ext[WIDTH];
      end
      OP_ASR: alu_y = asr_y;
      OP_LSR: alu_y = lsr_y;
      OP_CSR: alu_y = csr_y;
      OP_CSL: alu_y = csl_y;
      default: alu_e = 1'b1;
    endcase
  end

`ifdef PIPELINED_ALU_MUL_EN
  // prod holds {partial high, remaining multiplier bits}; shifts right one bit per step
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]     madd;

  assign madd      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {madd, prod_q[WIDTH-1:1]};
  assign in_ready  = (state_q != BUSY) && (!out_valid || out_ready);
`else
  assign in_ready  = !out_valid || out_ready;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    status_d = status_q;
`ifdef PIPELINED_ALU_MUL_EN
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    if (state_q == BUSY) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d  = DONE;
        y_d      = prod_step[WIDTH-1:0];
        status_d = pack_status(prod_step[WIDTH-1:0], 1'b0, 1'b0,
                               |prod_step[2*WIDTH-1:WIDTH]);
      end
    end else if (accept && opcode == OP_MUL) begin
      state_d = BUSY;
      prod_d  = {{WIDTH{1'b0}}, b};
      mcand_d = a;
      cnt_d   = '0;
    end else
`endif
    if (accept) begin
      state_d  = DONE;
      y_d      = alu_y;
      status_d = pack_status(alu_y, alu_e, alu_v, alu_c);
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      y_q      <= '0;
      status_q <= '0;
`ifdef PIPELINED_ALU_MUL_EN
      prod_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      status_q <= status_d;
`ifdef PIPELINED_ALU_MUL_EN
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign status    = status_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed-vector bench for pipelined_alu (WIDTH=16); MUL expectations follow PIPELINED_ALU_MUL_EN.
module tb_pipelined_alu;
  localparam int W = 16;

  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [5:0]   st;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [5:0]   status;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .status(status)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = '0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (y !== 16'h0000 || status !== 6'b000000) begin
      miscompares++; $display("FAIL reset_y_status: got y=%h st=%b want y=0000 st=000000", y, status);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_alu_back_to_back();
    vec_t tbl[$];
    tbl.push_back({5'd0,  16'h7FFF, 16'h0001, 16'h8000, 6'b011100});
    tbl.push_back({5'd1,  16'h0000, 16'h0001, 16'hFFFF, 6'b000101});
    tbl.push_back({5'd2,  16'h8000, 16'h0000, 16'h8000, 6'b011101});
    tbl.push_back({5'd13, 16'h8001, 16'h0001, 16'h0002, 6'b010001});
    tbl.push_back({5'd14, 16'h8001, 16'h0001, 16'hC000, 6'b000100});
    tbl.push_back({5'd10, 16'h8000, 16'h000F, 16'hFFFF, 6'b000100});
    tbl.push_back({5'd3,  16'hFFFF, 16'h0000, 16'h0000, 6'b000011});
    tbl.push_back({5'd4,  16'h8000, 16'h0000, 16'h7FFF, 6'b011000});
    tbl.push_back({5'd5,  16'h0007, 16'hFFFF, 16'h0007, 6'b010000});
    tbl.push_back({5'd6,  16'hF0F0, 16'h0F0F, 16'h0000, 6'b000010});
    tbl.push_back({5'd7,  16'h1234, 16'h0001, 16'h1235, 6'b000000});
    tbl.push_back({5'd8,  16'h00FF, 16'h0F0F, 16'h0FF0, 6'b000000});
    tbl.push_back({5'd9,  16'h0000, 16'h1234, 16'hFFFF, 6'b000100});
    tbl.push_back({5'd12, 16'h8000, 16'h0004, 16'h0800, 6'b010000});
    tbl.push_back({5'd15, 16'h8001, 16'h0004, 16'h0018, 6'b000000});
    tbl.push_back({5'd11, 16'h4000, 16'h0000, 16'h4000, 6'b010000});
    tbl.push_back({5'd11, 16'hC000, 16'h0002, 16'h0000, 6'b000011});
    tbl.push_back({5'd31, 16'h0005, 16'h0003, 16'h0000, 6'b100010});
    tbl.push_back({5'd17, 16'h1234, 16'h5678, 16'h0000, 6'b100010});
    tbl.push_back({5'd2,  16'h0000, 16'h0000, 16'h0000, 6'b000010});
    tbl.push_back({5'd1,  16'h8000, 16'h0001, 16'h7FFF, 6'b011000});
    tbl.push_back({5'd0,  16'hFFFF, 16'hFFFF, 16'hFFFE, 6'b010101});
    tbl.push_back({5'd10, 16'h4000, 16'h0003, 16'h0800, 6'b010000});
    tbl.push_back({5'd14, 16'h0001, 16'h0000, 16'h0001, 6'b010000});
    out_ready = 1'b1;
    for (int i = 0; i < int'(tbl.size()); i++) begin
      opcode = tbl[i].op; a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL alu_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || y !== tbl[i].y || status !== tbl[i].st) begin
        miscompares++;
        $display("FAIL alu_vec[%0d] op=%0d: got v=%b y=%h st=%b want v=1 y=%h st=%b",
                 i, tbl[i].op, out_valid, y, status, tbl[i].y, tbl[i].st);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL alu_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    opcode = 5'd0; a = 16'h0001; b = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || y !== 16'h0004 || status !== 6'b010000) begin
      miscompares++; $display("FAIL bp_first: got v=%b y=%h st=%b want v=1 y=0004 st=010000", out_valid, y, status);
    end
    opcode = 5'd1; a = 16'h0005; b = 16'h0007;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 16'h0004 || status !== 6'b010000) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b y=%h st=%b want rdy=0 v=1 y=0004 st=010000",
                 k, in_ready, out_valid, y, status);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_rdy: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || y !== 16'hFFFE || status !== 6'b010101) begin
      miscompares++; $display("FAIL bp_next: got v=%b y=%h st=%b want v=1 y=fffe st=010101", out_valid, y, status);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_mul();
    logic [W-1:0] ma [2];
    logic [W-1:0] mb [2];
    logic [W-1:0] ey [2];
    logic [5:0]   est [2];
    ma[0] = 16'h0100; mb[0] = 16'h0100;
    ma[1] = 16'h00FF; mb[1] = 16'h0101;
`ifdef PIPELINED_ALU_MUL_EN
    ey[0] = 16'h0000; est[0] = 6'b000011;
    ey[1] = 16'hFFFF; est[1] = 6'b000100;
`else
    ey[0] = 16'h0000; est[0] = 6'b100010;
    ey[1] = 16'h0000; est[1] = 6'b100010;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      opcode = 5'd16; a = ma[i]; b = mb[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A;
`ifdef PIPELINED_ALU_MUL_EN
      for (int k = 0; k < W; k++) begin
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL mul_busy[%0d] cycle %0d: got v=%b rdy=%b want 0/0", i, k, out_valid, in_ready);
        end
        @(posedge clk); #1;
      end
`endif
      vectors++;
      if (out_valid !== 1'b1 || y !== ey[i] || status !== est[i]) begin
        miscompares++;
        $display("FAIL mul_result[%0d]: got v=%b y=%h st=%b want v=1 y=%h st=%b",
                 i, out_valid, y, status, ey[i], est[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mul_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b0;
    opcode = 5'd16; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || status !== 6'b000000 || y !== 16'h0000 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b st=%b y=%h rdy=%b want v=0 st=000000 y=0000 rdy=1",
               out_valid, status, y, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (W + 2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL aborted_result: got out_valid=%b want 0", out_valid); end
    opcode = 5'd0; a = 16'hFFFF; b = 16'h0002; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || y !== 16'h0001 || status !== 6'b010001) begin
      miscompares++; $display("FAIL post_reset_add: got v=%b y=%h st=%b want v=1 y=0001 st=010001", out_valid, y, status);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_backpressure();
    test_mul();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
